// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity encodings, transmitter
// state type and frame-length helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Serial bits per frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word handshake between a message source and the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty; power-of-two depth.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata_c = mem[rptr];

    always_comb begin
        count_n = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered words serialised LSB-first with
// optional parity and one or two stop bits.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_cfg_if.slave                tx_if,
    input  logic                        tx_enable,
    output logic                        ser_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned CNT_W = 4;

    tx_state_e            state, state_n;
    logic [DIV_W-1:0]     div_cnt, div_n;
    logic [CNT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic                 par_q, par_n;
    logic                 ser_n, busy_n;

    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] head_c;
    logic                 push_c, pop_c;
    logic                 wrap_c, last_stop_c, start_c;

    assign tx_if.tx_ready = ~fifo_full;
    assign push_c         = tx_if.tx_valid & ~fifo_full;
    assign wrap_c         = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_stop_c    = (state == ST_STOP) && wrap_c && (bit_cnt == CNT_W'(STOP_BITS - 1));
    assign start_c        = tx_enable & ~fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (tx_if.tx_data),
        .rdata_c (head_c),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state and next-output logic; ser_out is the registered line level.
    always_comb begin
        state_n = state;
        div_n   = wrap_c ? '0 : div_cnt + DIV_W'(1);
        bit_n   = bit_cnt;
        shift_n = shift_q;
        par_n   = par_q;
        ser_n   = ser_out;
        busy_n  = busy;
        pop_c   = 1'b0;

        case (state)
            ST_IDLE: begin
                div_n  = '0;
                bit_n  = '0;
                ser_n  = 1'b1;
                busy_n = 1'b0;
            end
            ST_START: begin
                if (wrap_c) begin
                    state_n = ST_DATA;
                    ser_n   = shift_q[0];
                    bit_n   = '0;
                end
            end
            ST_DATA: begin
                if (wrap_c) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                        bit_n = '0;
                        if (PARITY == PAR_ODD || PARITY == PAR_EVEN) begin
                            state_n = ST_PARITY;
                            ser_n   = (PARITY == PAR_EVEN) ? par_q : ~par_q;
                        end else begin
                            state_n = ST_STOP;
                            ser_n   = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + CNT_W'(1);
                        ser_n = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (wrap_c) begin
                    state_n = ST_STOP;
                    ser_n   = 1'b1;
                end
            end
            ST_STOP: begin
                if (wrap_c) begin
                    if (last_stop_c) begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Frame launch from idle or straight out of the final stop cycle.
        if (start_c && (state == ST_IDLE || last_stop_c)) begin
            pop_c   = 1'b1;
            shift_n = head_c;
            par_n   = ^head_c;
            state_n = ST_START;
            ser_n   = 1'b0;
            busy_n  = 1'b1;
            div_n   = '0;
            bit_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ser_out <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            shift_q <= shift_n;
            par_q   <= par_n;
            ser_out <= ser_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four instances cover 8N1, even/odd parity and
// 7-bit/2-stop framing; instance 0 also covers queueing, reset and back-to-back.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en0;
    logic       ser  [4];
    logic       busy [4];
    logic [2:0] cnt  [4];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    logic       seen_low;

    uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_if(if0), .tx_enable(en0),
        .ser_out(ser[0]), .busy(busy[0]), .fifo_count(cnt[0]));
    uart_tx_cfg #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_if(if1), .tx_enable(1'b1),
        .ser_out(ser[1]), .busy(busy[1]), .fifo_count(cnt[1]));
    uart_tx_cfg #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_if(if2), .tx_enable(1'b1),
        .ser_out(ser[2]), .busy(busy[2]), .fifo_count(cnt[2]));
    uart_tx_cfg #(.DATA_BITS(7), .CLK_DIV(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_if(if3), .tx_enable(1'b1),
        .ser_out(ser[3]), .busy(busy[3]), .fifo_count(cnt[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, n_fail);
        end
    endtask

    // Single-word push on one instance; returns just after the accepting edge.
    task automatic push(input int d, input logic [7:0] v);
        case (d)
            0: begin if0.tx_data = v;      if0.tx_valid = 1'b1; end
            1: begin if1.tx_data = v;      if1.tx_valid = 1'b1; end
            2: begin if2.tx_data = v;      if2.tx_valid = 1'b1; end
            default: begin if3.tx_data = v[6:0]; if3.tx_valid = 1'b1; end
        endcase
        tick();
        if0.tx_valid = 1'b0;
        if1.tx_valid = 1'b0;
        if2.tx_valid = 1'b0;
        if3.tx_valid = 1'b0;
    endtask

    // Back-to-back pushes into instance 0; word i is words[8*i +: 8].
    task automatic fill0(input int n, input logic [31:0] words);
        if0.tx_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            if0.tx_data = words[8*i +: 8];
            tick();
        end
        if0.tx_valid = 1'b0;
    endtask

    // Checks line level and busy every cycle of a frame; bits[0] is sent first.
    task automatic frame(input int d, input logic [10:0] bits, input int n);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("ser d%0d bit%0d cyc%0d", d, b, c), 32'(ser[d]), 32'(bits[b]));
                chk($sformatf("busy d%0d bit%0d cyc%0d", d, b, c), 32'(busy[d]), 32'd1);
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b1;
        if0.tx_valid = 1'b0; if0.tx_data = '0;
        if1.tx_valid = 1'b0; if1.tx_data = '0;
        if2.tx_valid = 1'b0; if2.tx_data = '0;
        if3.tx_valid = 1'b0; if3.tx_data = '0;
        tick();
        tick();

        // Reset state
        chk("rst ser",   32'(ser[0]),       32'd1);
        chk("rst busy",  32'(busy[0]),      32'd0);
        chk("rst count", 32'(cnt[0]),       32'd0);
        chk("rst ready", 32'(if0.tx_ready), 32'd1);
        for (int d = 1; d < 4; d++) chk($sformatf("rst ser d%0d", d), 32'(ser[d]), 32'd1);
        rst = 1'b0;
        tick();

        // 8N1, 0x4E: one-cycle latency, then 40-cycle frame
        push(0, 8'h4E);
        chk("8n1 count after push", 32'(cnt[0]), 32'd1);
        chk("8n1 line still idle",  32'(ser[0]), 32'd1);
        tick();
        chk("8n1 count after pop", 32'(cnt[0]), 32'd0);
        frame(0, 11'h29C, 10);
        chk("8n1 busy end", 32'(busy[0]), 32'd0);
        chk("8n1 ser end",  32'(ser[0]),  32'd1);

        // Even parity: parity bit 0, 44 cycles
        push(1, 8'h4E);
        tick();
        frame(1, 11'h49C, 11);
        chk("even busy end", 32'(busy[1]), 32'd0);
        chk("even ser end",  32'(ser[1]),  32'd1);

        // Odd parity: parity bit 1
        push(2, 8'h4E);
        tick();
        frame(2, 11'h69C, 11);
        chk("odd busy end", 32'(busy[2]), 32'd0);

        // 7 data bits, 2 stop bits, 0x41
        push(3, 8'h41);
        tick();
        frame(3, 11'h382, 10);
        chk("7n2 busy end", 32'(busy[3]), 32'd0);
        chk("7n2 ser end",  32'(ser[3]),  32'd1);

        // Disabled: queue fills, overflow push ignored, line idle
        en0 = 1'b0;
        fill0(4, 32'h04030201);
        if0.tx_data  = 8'h05;
        if0.tx_valid = 1'b1;
        tick();
        if0.tx_valid = 1'b0;
        chk("full count", 32'(cnt[0]),       32'd4);
        chk("full ready", 32'(if0.tx_ready), 32'd0);
        tick();
        tick();
        chk("disabled ser",  32'(ser[0]),  32'd1);
        chk("disabled busy", 32'(busy[0]), 32'd0);
        en0 = 1'b1;
        tick();
        chk("first pop count", 32'(cnt[0]),       32'd3);
        chk("first pop ready", 32'(if0.tx_ready), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            logic [7:0] w;
            w = 8'(i);
            frame(0, {1'b0, 1'b1, w, 1'b0}, 10);
        end
        chk("burst busy end",  32'(busy[0]), 32'd0);
        chk("burst ser end",   32'(ser[0]),  32'd1);
        chk("burst count end", 32'(cnt[0]),  32'd0);

        // Reset in the middle of the second frame's data bits
        en0 = 1'b0;
        fill0(4, 32'h693C5AA5);
        en0 = 1'b1;
        tick();
        frame(0, 11'h34A, 10);
        repeat (12) tick();
        chk("pre-reset count", 32'(cnt[0]),  32'd2);
        chk("pre-reset busy",  32'(busy[0]), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid rst ser",   32'(ser[0]),       32'd1);
        chk("mid rst busy",  32'(busy[0]),      32'd0);
        chk("mid rst count", 32'(cnt[0]),       32'd0);
        chk("mid rst ready", 32'(if0.tx_ready), 32'd1);
        rst = 1'b0;
        seen_low = 1'b0;
        repeat (60) begin
            tick();
            if (ser[0] !== 1'b1) seen_low = 1'b1;
        end
        chk("no frame after reset", 32'(seen_low), 32'd0);

        // Push coinciding with the last stop cycle that pops the final word
        en0 = 1'b0;
        fill0(2, 32'h0000334E);
        en0 = 1'b1;
        tick();
        chk("b2b count start", 32'(cnt[0]), 32'd1);
        repeat (39) tick();
        chk("b2b last stop ser",  32'(ser[0]),  32'd1);
        chk("b2b last stop busy", 32'(busy[0]), 32'd1);
        if0.tx_data  = 8'hC3;
        if0.tx_valid = 1'b1;
        tick();
        if0.tx_valid = 1'b0;
        chk("b2b count unchanged", 32'(cnt[0]), 32'd1);
        frame(0, 11'h266, 10);
        frame(0, 11'h386, 10);
        chk("b2b busy end",  32'(busy[0]), 32'd0);
        chk("b2b count end", 32'(cnt[0]),  32'd0);
        chk("b2b ser end",   32'(ser[0]),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 logo transmitter. Accepts words over a valid/ready handshake into a small internal FIFO, then serialises them LSB-first. Data width, parity mode, stop-bit count, baud divider and FIFO depth are configurable. Sits between any on-chip message source (logo ROM sequencer, debug console) and the board TX pin.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9
CLK_DIV, 16, clk cycles per serial bit, minimum 2
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of two, minimum 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset (one clock; reset is synchronous and active-high)
tx_data  in  DATA_BITS  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  FIFO can accept; high whenever FIFO not full
tx_enable  in  1  0: no new frame starts; a frame in progress completes
ser_out  out  1  serial line, idle high, registered
busy  out  1  high from START entry through last STOP cycle
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (sampled at rising edge): ser_out=1, busy=0, tx_ready=1 (from the following cycle onward), fifo_count=0. FIFO contents are discarded, state goes to IDLE, bit and divider counters are cleared. A reset mid-frame truncates the frame immediately; the line is high on the next edge.
- Push: on an edge where tx_valid and tx_ready are both high, tx_data is written and fifo_count increments. tx_valid while tx_ready=0 is ignored (no overflow state). The source must hold data until accepted.
- Pop: in IDLE (or in the last cycle of the last STOP bit), with fifo_count>0 and tx_enable=1, the head word is popped into the shift register. The state enters START and ser_out<=0 on the same edge.
- Simultaneous push and pop: fifo_count is unchanged and both operations take effect. Push when full is impossible because tx_ready=0. A pop that empties the FIFO while a push occurs leaves count unchanged.
- States:
  - IDLE: ser_out=1.
  - START: ser_out=0.
  - DATA: ser_out=shift[0], shift right each bit.
  - PARITY: only if PARITY!=0. Even mode sends XOR of the data bits. Odd mode sends the inverted XOR.
  - STOP: ser_out=1, repeated STOP_BITS times.
  - Transitions: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE or START.
- Bit timing: every bit holds for exactly CLK_DIV cycles. The divider counts 0..CLK_DIV-1 and wraps, and bit/state advance happens on the wrap.
- Frame length: (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles.
- Back-to-back: if a word is available at the final STOP cycle, the next START follows with zero idle cycles.
- Latency: push into an empty FIFO in IDLE at edge N gives ser_out=0 from edge N+1.
- tx_enable=0: the FIFO still accepts pushes. A frame in progress finishes normally. IDLE holds until tx_enable returns high.
- busy falls on the edge ending the last STOP bit, unless the next frame starts on that same edge.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - tx state enum (IDLE, START, DATA, PARITY, STOP);
  - function frame_bits(data_bits, parity, stop_bits).
- One sub-module, uart_sync_fifo: parametrised width/depth synchronous FIFO with push/pop, full/empty and count. It is reusable by the future receiver.

Test Plan:
- CLK_DIV=4, 8N1, push 0x4E into idle FIFO -> starting one cycle later, ser_out = 0,0,1,1,1,0,0,1,0,1, each level held 4 cycles. 40 cycles total, then busy=0 and ser_out=1.
- Same word, PARITY=2 (even) -> parity bit 0 after data, frame 44 cycles. PARITY=1 (odd) -> parity bit 1.
- DATA_BITS=7, STOP_BITS=2, push 0x41 -> 0,1,0,0,0,0,0,1,1,1, frame 40 cycles at CLK_DIV=4.
- tx_enable=0, push 0x01..0x04 with FIFO_DEPTH=4 -> fifo_count=4, tx_ready=0, ser_out stays 1. Then tx_enable=1 -> four contiguous frames with no idle gap, and tx_ready=1 one cycle after the first pop.
- Assert rst mid-DATA of the second frame with 2 words queued -> next edge ser_out=1, busy=0, fifo_count=0. After release, no frame is transmitted.
- Push while the last STOP cycle pops the final queued word -> fifo_count is unchanged that edge, and the new word transmits immediately after the current frame.
